// File: rtl/ofs_asp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofs_asp_pkg
//  Description : Shared constants and types for the ASP interrupt responder.
//                Holds the interrupt bit map, the CSR byte offsets, the width
//                of the host vector index and the responder FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofs_asp_pkg;

    // Interrupt sources wired into the responder and their bit positions.
    localparam int BSP_AVMM_NUM_IRQ_USED = 3;
    localparam int BSP_DMA_0_IRQ_BIT     = 0;
    localparam int BSP_KERNEL_IRQ_BIT    = 1;
    localparam int BSP_DMA_1_IRQ_BIT     = 2;

    // Width of the vector index presented to the host (supports up to 4 sources).
    localparam int IRQ_VEC_W = 2;

    // CSR byte offsets (8-byte aligned).
    localparam logic [31:0] IRQ_CSR_PENDING = 32'h0000_0000;
    localparam logic [31:0] IRQ_CSR_MASK    = 32'h0000_0008;
    localparam logic [31:0] IRQ_CSR_CLEAR   = 32'h0000_0010;
    localparam logic [31:0] IRQ_CSR_COUNT   = 32'h0000_0018;
    localparam logic [31:0] IRQ_CSR_DEBUG   = 32'h0000_0020;

    // Host request state machine.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } irq_fsm_t;

endpackage : ofs_asp_pkg
`default_nettype wire

// File: rtl/asp_irq_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : asp_irq_rr_arb
//  Description : Round-robin picker for the interrupt responder. The grant is
//                purely combinational from the eligible vector; the search
//                starts one position after the last accepted vector. Only the
//                pointer is registered, and it moves on accept.
//  Ports       : clk, reset_n     - clock / async active-low reset
//                req_i            - eligible sources
//                accept_i         - host accepted a request this cycle
//                accept_vec_i     - vector that was accepted
//                grant_valid_o    - at least one source is eligible
//                grant_vec_o      - chosen vector index
//  Revision    : 1.0 - initial release
// ============================================================================
module asp_irq_rr_arb
    import ofs_asp_pkg::*;
#(
    parameter int NUM_IRQ = ofs_asp_pkg::BSP_AVMM_NUM_IRQ_USED
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_IRQ-1:0]   req_i,
    input  logic                 accept_i,
    input  logic [IRQ_VEC_W-1:0] accept_vec_i,
    output logic                 grant_valid_o,
    output logic [IRQ_VEC_W-1:0] grant_vec_o
);

    logic [IRQ_VEC_W-1:0] ptr_q;
    logic [IRQ_VEC_W-1:0] ptr_d;
    logic [3:0]           req_pad;
    int                   cand;

    // Walk offsets from farthest to nearest so the nearest eligible source
    // after the pointer is the last (winning) assignment.
    always_comb begin
        req_pad       = 4'(req_i);
        grant_valid_o = 1'b0;
        grant_vec_o   = '0;
        cand          = 0;
        for (int off = NUM_IRQ; off >= 1; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_IRQ) begin
                cand = cand - NUM_IRQ;
            end
            if (req_pad[2'(cand)]) begin
                grant_valid_o = 1'b1;
                grant_vec_o   = 2'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = accept_vec_i;
        end
    end

    // Reset points at the last source so vector 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 2'(NUM_IRQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : asp_irq_rr_arb
`default_nettype wire

// File: rtl/asp_irq_responder.sv
`default_nettype none
// ============================================================================
//  Module      : asp_irq_responder
//  Description : Collects level interrupts into sticky pending bits, offers
//                one host request per pending episode (round-robin across
//                sources) and enforces a hold-off gap between requests.
//                An AVMM CSR slave exposes pending/mask/clear/count/debug.
//  Ports       : clk, reset_n              - clock / async active-low reset
//                irq_in                    - level interrupt lines
//                csr_address/read/write/
//                csr_writedata/byteenable  - AVMM slave command side
//                csr_readdata/readdatavalid- 1-cycle read response
//                csr_waitrequest           - always 0
//                irq_req_valid/vec/ready   - host interrupt request handshake
//  Note        : the debug register at 0x20 needs CSR_ADDR_WIDTH >= 6 to be
//                reachable; narrower address buses simply never decode it.
//  Revision    : 1.0 - initial release
// ============================================================================
module asp_irq_responder
    import ofs_asp_pkg::*;
#(
    parameter int NUM_IRQ        = ofs_asp_pkg::BSP_AVMM_NUM_IRQ_USED,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CSR_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IRQ-1:0]        irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
    input  logic                      csr_read,
    input  logic                      csr_write,
    input  logic [63:0]               csr_writedata,
    input  logic [7:0]                csr_byteenable,
    output logic [63:0]               csr_readdata,
    output logic                      csr_readdatavalid,
    output logic                      csr_waitrequest,
    output logic                      irq_req_valid,
    output logic [IRQ_VEC_W-1:0]      irq_req_vec,
    input  logic                      irq_req_ready
);

    irq_fsm_t             state_q, state_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   issued_q, issued_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [31:0]          count_q, count_d;
    logic [7:0]           hold_q, hold_d;
    logic [IRQ_VEC_W-1:0] vec_q, vec_d;
    logic [63:0]          readdata_q, readdata_d;
    logic                 rdvalid_q;

    logic [31:0]          addr_ext;
    logic                 wr_mask;
    logic                 wr_clear;
    logic [NUM_IRQ-1:0]   clr_bits;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   acc_onehot;
    logic                 accept;
    logic                 grant_valid;
    logic [IRQ_VEC_W-1:0] grant_vec;
    logic [63:0]          rdata;
    logic                 unused_bits;

    assign csr_waitrequest   = 1'b0;
    assign csr_readdata      = readdata_q;
    assign csr_readdatavalid = rdvalid_q;
    assign irq_req_valid     = (state_q == REQ);
    assign irq_req_vec       = vec_q;

    // Only byte 0 carries mask/clear bits; the rest of the write bus is ignored.
    assign unused_bits = ^{csr_writedata[63:NUM_IRQ], csr_byteenable[7:1]};

    // ------------------------------------------------------------------
    // CSR decode
    // ------------------------------------------------------------------
    assign addr_ext = 32'(csr_address);
    assign wr_mask  = csr_write && csr_byteenable[0] && (addr_ext == IRQ_CSR_MASK);
    assign wr_clear = csr_write && csr_byteenable[0] && (addr_ext == IRQ_CSR_CLEAR);
    assign clr_bits = wr_clear ? csr_writedata[NUM_IRQ-1:0] : '0;

    always_comb begin
        rdata = '0;
        if (addr_ext == IRQ_CSR_PENDING) begin
            rdata[NUM_IRQ-1:0] = pending_q;
        end else if (addr_ext == IRQ_CSR_MASK) begin
            rdata[NUM_IRQ-1:0] = mask_q;
        end else if (addr_ext == IRQ_CSR_COUNT) begin
            rdata[31:0] = count_q;
        end else if (addr_ext == IRQ_CSR_DEBUG) begin
            rdata[NUM_IRQ+7:8] = issued_q;
            rdata[NUM_IRQ-1:0] = pending_q;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (csr_read) begin
            readdata_d = rdata;
        end
    end

    // ------------------------------------------------------------------
    // Pending / issued / mask tracking
    // ------------------------------------------------------------------
    assign accept     = (state_q == REQ) && irq_req_ready;
    assign acc_onehot = accept ? (NUM_IRQ'(1) << vec_q) : '0;
    assign eligible   = pending_q & ~issued_q & ~mask_q;

    // New interrupt activity is OR'd in after the clear so a colliding set wins.
    // A W1C always retires the issued bit, which re-arms the source for a fresh
    // request even when the set kept pending high.
    always_comb begin
        pending_d = (pending_q & ~clr_bits) | (irq_in & ~mask_q);
        issued_d  = (issued_q & ~clr_bits) | acc_onehot;
        mask_d    = wr_mask ? csr_writedata[NUM_IRQ-1:0] : mask_q;
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    asp_irq_rr_arb #(
        .NUM_IRQ (NUM_IRQ)
    ) u_rr_arb (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_i         (eligible),
        .accept_i      (accept),
        .accept_vec_i  (vec_q),
        .grant_valid_o (grant_valid),
        .grant_vec_o   (grant_vec)
    );

    // The vector is latched on entry to REQ, so later mask/clear writes cannot
    // change or withdraw an outstanding request.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = REQ;
                    vec_d   = grant_vec;
                end
            end
            REQ: begin
                if (irq_req_ready) begin
                    state_d = HOLDOFF;
                    hold_d  = 8'(HOLDOFF_CYCLES - 1);
                    count_d = count_q + 32'd1;
                end
            end
            HOLDOFF: begin
                // Leave as the counter lands on zero, giving HOLDOFF_CYCLES+1
                // cycles between consecutive request starts.
                hold_d = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;
                if (hold_q <= 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            issued_q   <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            vec_q      <= '0;
            readdata_q <= '0;
            rdvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            issued_q   <= issued_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            vec_q      <= vec_d;
            readdata_q <= readdata_d;
            rdvalid_q  <= csr_read;
        end
    end

endmodule : asp_irq_responder
`default_nettype wire

// File: tb/tb_asp_irq_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asp_irq_responder
//  Description : Directed self-checking bench for asp_irq_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asp_irq_responder;

    localparam logic [5:0] A_PEND  = 6'h00;
    localparam logic [5:0] A_MASK  = 6'h08;
    localparam logic [5:0] A_CLEAR = 6'h10;
    localparam logic [5:0] A_COUNT = 6'h18;
    localparam logic [5:0] A_DEBUG = 6'h20;
    localparam logic [5:0] A_NONE  = 6'h28;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  irq_in;
    logic [5:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [63:0] csr_writedata;
    logic [7:0]  csr_byteenable;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;
    logic        irq_req_valid;
    logic [1:0]  irq_req_vec;
    logic        irq_req_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    asp_irq_responder #(
        .NUM_IRQ        (3),
        .HOLDOFF_CYCLES (4),
        .CSR_ADDR_WIDTH (6)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .irq_in            (irq_in),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_byteenable    (csr_byteenable),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .csr_waitrequest   (csr_waitrequest),
        .irq_req_valid     (irq_req_valid),
        .irq_req_vec       (irq_req_vec),
        .irq_req_ready     (irq_req_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n        = 1'b0;
        irq_in         = '0;
        csr_address    = '0;
        csr_read       = 1'b0;
        csr_write      = 1'b0;
        csr_writedata  = '0;
        csr_byteenable = '0;
        irq_req_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic csr_wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        csr_address    = a;
        csr_writedata  = d;
        csr_byteenable = be;
        csr_write      = 1'b1;
        tick();
        csr_write      = 1'b0;
        csr_byteenable = '0;
    endtask

    task automatic csr_rd(input logic [5:0] a, output logic [63:0] d, output logic v);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        csr_read    = 1'b0;
        d = csr_readdata;
        v = csr_readdatavalid;
    endtask

    task automatic test_reset;
        logic [63:0] d;
        logic        v;
        logic [5:0]  addrs [4];
        addrs = '{A_PEND, A_MASK, A_COUNT, A_DEBUG};
        do_reset();
        reset_n = 1'b0;
        tick();
        total++;
        if (irq_req_valid !== 1'b0 || csr_readdatavalid !== 1'b0 || csr_readdata !== 64'h0
            || csr_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b rdv=%b rdata=%h wreq=%b required 0,0,0,0",
                     irq_req_valid, csr_readdatavalid, csr_readdata, csr_waitrequest);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            csr_rd(addrs[i], d, v);
            total++;
            if (v !== 1'b1 || d !== 64'h0) begin
                bad++;
                $display("FAIL reset_csr[%0h]: got v=%b d=%h required v=1 d=0", addrs[i], v, d);
            end
        end
        tick();
        total++;
        if (csr_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL rdv_pulse: got %b required 0", csr_readdatavalid);
        end
    endtask

    task automatic test_single;
        logic [63:0] d;
        logic        v;
        do_reset();
        irq_req_ready = 1'b1;
        irq_in = 3'b010;
        tick();
        irq_in = 3'b000;
        total++;
        if (irq_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got valid=%b required 0", irq_req_valid);
        end
        tick();
        total++;
        if (irq_req_valid !== 1'b1 || irq_req_vec !== 2'd1) begin
            bad++;
            $display("FAIL single_req: got valid=%b vec=%0d required 1,1", irq_req_valid, irq_req_vec);
        end
        tick();
        total++;
        if (irq_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drop: got valid=%b required 0", irq_req_valid);
        end
        csr_rd(A_COUNT, d, v);
        total++;
        if (d !== 64'd1) begin
            bad++;
            $display("FAIL single_count: got %h required 1", d);
        end
        csr_rd(A_PEND, d, v);
        total++;
        if (d !== 64'h2) begin
            bad++;
            $display("FAIL single_pending: got %h required 2", d);
        end
        csr_rd(A_DEBUG, d, v);
        total++;
        if (d !== 64'h202) begin
            bad++;
            $display("FAIL single_debug: got %h required 202", d);
        end
    endtask

    task automatic test_round_robin;
        int         n;
        int         at [3];
        logic [1:0] vv [3];
        int         found;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            at[k] = -1;
            vv[k] = 2'd3;
        end
        do_reset();
        irq_req_ready = 1'b1;
        irq_in = 3'b111;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (irq_req_valid === 1'b1) begin
                if (n < 3) begin
                    at[n] = i;
                    vv[n] = irq_req_vec;
                end
                n++;
            end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL rr_count: got %0d requests required 3", n);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (int'(vv[k]) != k || at[k] != 1 + 5 * k) begin
                bad++;
                $display("FAIL rr_req%0d: got vec=%0d cycle=%0d required vec=%0d cycle=%0d",
                         k, vv[k], at[k], k, 1 + 5 * k);
            end
        end
        csr_wr(A_CLEAR, 64'h7, 8'hFF);
        found = -1;
        for (int i = 0; i < 4; i++) begin
            if (found < 0 && irq_req_valid === 1'b1) begin
                found = int'(irq_req_vec);
            end
            tick();
        end
        irq_in = 3'b000;
        total++;
        if (found != 0) begin
            bad++;
            $display("FAIL rr_after_w1c: got vec=%0d required 0", found);
        end
    endtask

    task automatic test_mask;
        logic [63:0] d;
        logic        v;
        logic        seen;
        do_reset();
        irq_req_ready = 1'b1;
        csr_wr(A_MASK, 64'h4, 8'hFF);
        csr_wr(A_MASK, 64'h0, 8'hFE);
        csr_rd(A_MASK, d, v);
        total++;
        if (d !== 64'h4) begin
            bad++;
            $display("FAIL mask_byteen: got %h required 4", d);
        end
        irq_in = 3'b100;
        tick();
        irq_in = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | irq_req_valid;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mask_blocks: got valid seen=%b required 0", seen);
        end
        csr_rd(A_PEND, d, v);
        total++;
        if (d !== 64'h0) begin
            bad++;
            $display("FAIL mask_pending: got %h required 0", d);
        end
        csr_wr(A_NONE, 64'hFF, 8'hFF);
        csr_rd(A_NONE, d, v);
        total++;
        if (d !== 64'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL unmapped: got v=%b d=%h required 1,0", v, d);
        end
        csr_wr(A_MASK, 64'h0, 8'h01);
        irq_in = 3'b100;
        tick();
        irq_in = 3'b000;
        tick();
        total++;
        if (irq_req_valid !== 1'b1 || irq_req_vec !== 2'd2) begin
            bad++;
            $display("FAIL unmask_req: got valid=%b vec=%0d required 1,2", irq_req_valid, irq_req_vec);
        end
    endtask

    task automatic test_stall;
        logic [63:0] d;
        logic        v;
        do_reset();
        irq_in = 3'b001;
        tick();
        irq_in = 3'b000;
        tick();
        total++;
        if (irq_req_valid !== 1'b1 || irq_req_vec !== 2'd0) begin
            bad++;
            $display("FAIL stall_start: got valid=%b vec=%0d required 1,0", irq_req_valid, irq_req_vec);
        end
        csr_wr(A_MASK, 64'h1, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (irq_req_valid !== 1'b1 || irq_req_vec !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold%0d: got valid=%b vec=%0d required 1,0",
                         i, irq_req_valid, irq_req_vec);
            end
        end
        irq_req_ready = 1'b1;
        tick();
        irq_req_ready = 1'b0;
        total++;
        if (irq_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_accept: got valid=%b required 0", irq_req_valid);
        end
        csr_rd(A_DEBUG, d, v);
        total++;
        if (d !== 64'h101) begin
            bad++;
            $display("FAIL stall_debug: got %h required 101", d);
        end
    endtask

    task automatic test_w1c_race;
        logic [63:0] d;
        logic        v;
        do_reset();
        irq_req_ready = 1'b1;
        irq_in = 3'b001;
        tick();
        irq_in = 3'b000;
        repeat (8) tick();
        csr_rd(A_DEBUG, d, v);
        total++;
        if (d !== 64'h101) begin
            bad++;
            $display("FAIL race_before: got %h required 101", d);
        end
        irq_in         = 3'b001;
        csr_address    = A_CLEAR;
        csr_writedata  = 64'h1;
        csr_byteenable = 8'hFF;
        csr_write      = 1'b1;
        tick();
        csr_write      = 1'b0;
        irq_in         = 3'b000;
        csr_rd(A_DEBUG, d, v);
        total++;
        if (d !== 64'h001) begin
            bad++;
            $display("FAIL race_debug: got %h required 001", d);
        end
        total++;
        if (irq_req_valid !== 1'b1 || irq_req_vec !== 2'd0) begin
            bad++;
            $display("FAIL race_rereq: got valid=%b vec=%0d required 1,0", irq_req_valid, irq_req_vec);
        end
        tick();
        csr_rd(A_COUNT, d, v);
        total++;
        if (d !== 64'd2) begin
            bad++;
            $display("FAIL race_count: got %h required 2", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d;
        logic        v;
        logic [5:0]  addrs [4];
        logic        seen;
        addrs = '{A_PEND, A_MASK, A_COUNT, A_DEBUG};
        do_reset();
        csr_wr(A_MASK, 64'h4, 8'hFF);
        irq_in = 3'b010;
        tick();
        irq_in = 3'b000;
        tick();
        total++;
        if (irq_req_valid !== 1'b1 || irq_req_vec !== 2'd1) begin
            bad++;
            $display("FAIL mid_req: got valid=%b vec=%0d required 1,1", irq_req_valid, irq_req_vec);
        end
        csr_address = A_PEND;
        csr_read    = 1'b1;
        tick();
        csr_read    = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (irq_req_valid !== 1'b0 || csr_readdatavalid !== 1'b0 || csr_readdata !== 64'h0) begin
            bad++;
            $display("FAIL mid_async: got valid=%b rdv=%b rdata=%h required 0,0,0",
                     irq_req_valid, csr_readdatavalid, csr_readdata);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            csr_rd(addrs[i], d, v);
            total++;
            if (d !== 64'h0) begin
                bad++;
                $display("FAIL mid_csr[%0h]: got %h required 0", addrs[i], d);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | irq_req_valid;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_quiet: got valid seen=%b required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_stall();
        test_w1c_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_asp_irq_responder
`default_nettype wire
